fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 92 +++++++++
 tb/tb_fifo_wr_arb.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: round-robin arbiter feeding one FIFO write port; define FIFO_WR_ARB_BURST_EN for locked bursts of up to BURST_LEN beats
module fifo_wr_arb #(
    parameter int NREQ = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NREQ-1:0]              req_valid,
    input  logic [NREQ*DATA_WIDTH-1:0]   req_data,
    output logic [NREQ-1:0]              req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [DATA_WIDTH-1:0]        fifo_din,
    output logic [$clog2(NREQ)-1:0]      grant_id,
    output logic                         busy
);
    localparam int IW = $clog2(NREQ);
    if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1 || BURST_LEN > 255) begin : g_bad_param
        $error("fifo_wr_arb: parameter out of range");
    end
    logic [IW-1:0] rr_ptr, rr_pick, last_id, cur_id, nxt_ptr;
    logic any_valid, xfer, done;
    assign any_valid = |req_valid;
    always_comb begin
        rr_pick = rr_ptr;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(rr_ptr) + k) % NREQ]) rr_pick = IW'((int'(rr_ptr) + k) % NREQ);
    end
`ifdef FIFO_WR_ARB_BURST_EN
    localparam int BW = $clog2(BURST_LEN + 1);
    typedef enum logic {ARB, LOCK} state_t;
    state_t state, state_nx;
    logic [IW-1:0] lock_id, lock_id_nx;
    logic [BW-1:0] beat_cnt, beat_cnt_nx;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ARB;
            lock_id <= '0;
            beat_cnt <= '0;
        end else begin
            state <= state_nx;
            lock_id <= lock_id_nx;
            beat_cnt <= beat_cnt_nx;
        end
    // A dropped valid on the locked producer releases the lock even if the FIFO is full.
    always_comb begin
        state_nx = state;
        lock_id_nx = lock_id;
        beat_cnt_nx = beat_cnt;
        done = 1'b0;
        cur_id = (state == LOCK) ? lock_id : rr_pick;
        xfer = ((state == LOCK) ? req_valid[lock_id] : any_valid) && !fifo_full;
        if (state == ARB) begin
            if (xfer && BURST_LEN > 1) begin
                state_nx = LOCK;
                lock_id_nx = rr_pick;
                beat_cnt_nx = BW'(1);
            end else if (xfer) begin
                done = 1'b1;
            end
        end else if (!req_valid[lock_id]) begin
            state_nx = ARB;
            beat_cnt_nx = '0;
            done = 1'b1;
        end else if (xfer) begin
            beat_cnt_nx = (beat_cnt + 1'b1 == BW'(BURST_LEN)) ? '0 : beat_cnt + 1'b1;
            state_nx = (beat_cnt + 1'b1 == BW'(BURST_LEN)) ? ARB : LOCK;
            done = (beat_cnt + 1'b1 == BW'(BURST_LEN));
        end
    end
    assign busy = (state == LOCK);
`else
    assign cur_id = rr_pick;
    assign xfer = any_valid && !fifo_full;
    assign done = xfer;
    assign busy = 1'b0;
`endif
    assign nxt_ptr = (cur_id == IW'(NREQ - 1)) ? '0 : cur_id + 1'b1;
    assign fifo_wr_en = rst_n && xfer;
    assign req_ready = fifo_wr_en ? NREQ'(1) << cur_id : '0;
    assign fifo_din = fifo_wr_en ? req_data[int'(cur_id) * DATA_WIDTH +: DATA_WIDTH] : '0;
    assign grant_id = !rst_n ? '0 : (any_valid || busy) ? cur_id : last_id;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rr_ptr <= '0;
            last_id <= '0;
        end else begin
            if (done) rr_ptr <= nxt_ptr;
            if (any_valid || busy) last_id <= cur_id;
        end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed checks of fifo_wr_arb, NREQ=4 DATA_WIDTH=8 BURST_LEN=4; expectations follow FIFO_WR_ARB_BURST_EN
`timescale 1ns/1ps
module tb_fifo_wr_arb;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] req_valid = '0;
    logic [31:0] req_data = 32'hA3A2A1A0;
    logic [3:0] req_ready;
    logic fifo_full = 1'b0;
    logic fifo_wr_en;
    logic [7:0] fifo_din;
    logic [1:0] grant_id;
    logic busy;
    logic [15:0] obs;
    int n_cmp = 0;
    int n_bad = 0;
    always #5 clk = ~clk;
    fifo_wr_arb #(.NREQ(4), .DATA_WIDTH(8), .BURST_LEN(4)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_din(fifo_din), .grant_id(grant_id), .busy(busy)
    );
    assign obs = {fifo_wr_en, grant_id, busy, req_ready, fifo_din};
    function automatic logic [15:0] expv(input int we, input int g, input int b);
        return {we != 0, 2'(g), b != 0, (we != 0) ? 4'(4'b0001 << g) : 4'b0000,
                (we != 0) ? 8'hA0 + 8'(g) : 8'h00};
    endfunction
    task automatic do_reset;
        req_valid = '0;
        fifo_full = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask
    task automatic test_reset;
        rst_n = 1'b0;
        req_valid = 4'hF;
        @(negedge clk);
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_held: we/gid/busy/ready/din=%h required %h", obs, 16'h0000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        req_valid = '0;
        @(negedge clk);
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_release: we/gid/busy/ready/din=%h required %h", obs, 16'h0000);
        end
    endtask
    task automatic test_round_robin;
        int we [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
`ifdef FIFO_WR_ARB_BURST_EN
        int gid [9] = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        int bsy [9] = '{0, 1, 1, 1, 0, 1, 1, 1, 0};
`else
        int gid [9] = '{0, 1, 2, 3, 0, 1, 2, 3, 0};
        int bsy [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        do_reset;
        for (int i = 0; i < 9; i++) begin
            req_valid = 4'b1111;
            fifo_full = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (obs !== expv(we[i], gid[i], bsy[i])) begin
                n_bad++;
                $display("FAIL round_robin cycle %0d: got %h required %h", i, obs, expv(we[i], gid[i], bsy[i]));
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_alternate;
        int we [8] = '{1, 1, 1, 1, 1, 1, 1, 1};
`ifdef FIFO_WR_ARB_BURST_EN
        int gid [8] = '{1, 1, 1, 1, 3, 3, 3, 3};
        int bsy [8] = '{0, 1, 1, 1, 0, 1, 1, 1};
`else
        int gid [8] = '{1, 3, 1, 3, 1, 3, 1, 3};
        int bsy [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        do_reset;
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b1010;
            fifo_full = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (obs !== expv(we[i], gid[i], bsy[i])) begin
                n_bad++;
                $display("FAIL alternate cycle %0d: got %h required %h", i, obs, expv(we[i], gid[i], bsy[i]));
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_early_release;
        int vld [4] = '{4'b1100, 4'b1100, 4'b1000, 4'b1000};
`ifdef FIFO_WR_ARB_BURST_EN
        int we [4] = '{1, 1, 0, 1};
        int gid [4] = '{2, 2, 2, 3};
        int bsy [4] = '{0, 1, 1, 0};
`else
        int we [4] = '{1, 1, 1, 1};
        int gid [4] = '{2, 3, 3, 3};
        int bsy [4] = '{0, 0, 0, 0};
`endif
        do_reset;
        for (int i = 0; i < 4; i++) begin
            req_valid = 4'(vld[i]);
            fifo_full = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (obs !== expv(we[i], gid[i], bsy[i])) begin
                n_bad++;
                $display("FAIL early_release cycle %0d: got %h required %h", i, obs, expv(we[i], gid[i], bsy[i]));
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_stall;
        int full [8] = '{0, 0, 1, 1, 1, 0, 0, 0};
        int we [8] = '{1, 1, 0, 0, 0, 1, 1, 1};
        int p0_writes = 0;
`ifdef FIFO_WR_ARB_BURST_EN
        int gid [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        int bsy [8] = '{0, 1, 1, 1, 1, 1, 1, 0};
        int p0_exp = 4;
`else
        int gid [8] = '{0, 1, 2, 2, 2, 2, 3, 0};
        int bsy [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
        int p0_exp = 2;
`endif
        do_reset;
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'b1111;
            fifo_full = full[i] != 0;
            @(negedge clk);
            if (fifo_wr_en && grant_id == 2'd0) p0_writes++;
            n_cmp++;
            if (obs !== expv(we[i], gid[i], bsy[i])) begin
                n_bad++;
                $display("FAIL stall cycle %0d: got %h required %h", i, obs, expv(we[i], gid[i], bsy[i]));
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (p0_writes != p0_exp) begin
            n_bad++;
            $display("FAIL stall_beats: producer 0 writes %0d required %0d", p0_writes, p0_exp);
        end
    endtask
    task automatic test_idle;
        int vld [8] = '{4'b0010, 0, 0, 0, 0, 0, 0, 4'b1111};
        int we [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
        int gid [8] = '{1, 1, 1, 1, 1, 1, 1, 2};
`ifdef FIFO_WR_ARB_BURST_EN
        int bsy [8] = '{0, 1, 0, 0, 0, 0, 0, 0};
`else
        int bsy [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
`endif
        do_reset;
        for (int i = 0; i < 8; i++) begin
            req_valid = 4'(vld[i]);
            fifo_full = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (obs !== expv(we[i], gid[i], bsy[i])) begin
                n_bad++;
                $display("FAIL idle cycle %0d: got %h required %h", i, obs, expv(we[i], gid[i], bsy[i]));
            end
            @(posedge clk);
            #1;
        end
    endtask
    task automatic test_reset_mid;
`ifdef FIFO_WR_ARB_BURST_EN
        int bsy1 = 1;
`else
        int bsy1 = 0;
`endif
        do_reset;
        req_valid = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if (obs !== expv(1, 3, 0)) begin
            n_bad++;
            $display("FAIL reset_mid_grant: got %h required %h", obs, expv(1, 3, 0));
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if (obs !== expv(1, 3, bsy1)) begin
            n_bad++;
            $display("FAIL reset_mid_lock: got %h required %h", obs, expv(1, 3, bsy1));
        end
        @(posedge clk);
        #1 req_valid = 4'b1001;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (obs !== 16'h0000) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %h required %h", obs, 16'h0000);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (obs !== expv(1, 0, 0)) begin
            n_bad++;
            $display("FAIL reset_mid_restart: got %h required %h", obs, expv(1, 0, 0));
        end
    endtask
    initial begin
        test_reset;
        test_round_robin;
        test_alternate;
        test_early_release;
        test_stall;
        test_idle;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
